// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-way, WIDTH-bit select multiplexer with a registered output
// stage, valid/ready handshake and a 2-entry skid buffer.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_data     packed inputs, input k at [k*WIDTH +: WIDTH]
//   sel         binary select, sampled together with in_data
//   in_valid    upstream offers in_data/sel
//   in_ready    block can accept this cycle (state only, never out_ready)
//   out         selected, registered data
//   out_err     out was produced by an out-of-range select
//   out_valid   out/out_err valid
//   out_ready   downstream accepts out this cycle
//   sel_err_cnt saturating count of accepted out-of-range selects
module mux_n_pipe #(
  parameter int WIDTH  = 24,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out,
  output logic                      out_err,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                sel_err_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic             r_main_err;
  logic [WIDTH-1:0] r_skid;
  logic             r_skid_err;
  logic [7:0]       r_cnt;

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_hit;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // A select that matches no implemented input yields zero data and flags
  // the error; this covers every code >= NUM_IN.
  always_comb begin
    w_sel_data = '0;
    w_sel_hit  = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        w_sel_data = in_data[k*WIDTH +: WIDTH];
        w_sel_hit  = 1'b1;
      end
    end
  end

  assign in_ready   = (r_state != S_TWO) & ~rst;
  assign out_valid  = (r_state != S_EMPTY);
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  assign out         = r_main;
  assign out_err     = r_main_err;
  assign sel_err_cnt = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_main     <= '0;
      r_main_err <= 1'b0;
      r_skid     <= '0;
      r_skid_err <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_in_xfer && !w_sel_hit && (r_cnt != 8'hFF)) begin
        r_cnt <= r_cnt + 8'd1;
      end

      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            r_main     <= w_sel_data;
            r_main_err <= ~w_sel_hit;
            r_state    <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_xfer && !w_out_xfer) begin
            // main is stalled: park the new beat behind it
            r_skid     <= w_sel_data;
            r_skid_err <= ~w_sel_hit;
            r_state    <= S_TWO;
          end else if (w_in_xfer && w_out_xfer) begin
            r_main     <= w_sel_data;
            r_main_err <= ~w_sel_hit;
          end else if (w_out_xfer) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_out_xfer) begin
            r_main     <= r_skid;
            r_main_err <= r_skid_err;
            r_state    <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
Parametrised N-way, WIDTH-bit select multiplexer for the FPAU datapath, successor to the fixed 2:1 muxes. It adds a registered output stage with a valid/ready handshake and a 2-entry skid buffer, so operand or mantissa selection can sit on a pipeline boundary of the square-root unit without stalling-induced data loss. Out-of-range selects are detected and flagged alongside the data they produced.

Parameters:
WIDTH, 24, data width per input (1..64)
NUM_IN, 4, number of inputs (2..16)
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
sel  input  SEL_W  binary select, sampled with in_data
in_valid  input  1  upstream has a valid in_data/sel
in_ready  output  1  block can accept this cycle
out  output  WIDTH  selected, registered data
out_err  output  1  registered flag: out came from an out-of-range sel
out_valid  output  1  out/out_err valid
out_ready  input  1  downstream accepts out this cycle
sel_err_cnt  output  8  saturating count of accepted out-of-range selects

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Input transfer: in_valid & in_ready at a rising edge. Output transfer: out_valid & out_ready at a rising edge.
- Selection is combinational on in_data/sel and is captured only on an input transfer.
- sel < NUM_IN: captured data = input[sel], err = 0.
- sel >= NUM_IN: captured data = all zeros, err = 1, and sel_err_cnt increments. The counter saturates at 255.
- Storage: a main register (drives out/out_err) and a skid register.
- States:
  - EMPTY: nothing held.
  - ONE: main holds data.
  - TWO: main and skid both hold data.
- Transitions (in = input transfer, o = output transfer):
  - EMPTY: in -> ONE, with the capture loaded into main.
  - ONE: in & !o -> TWO, with the capture loaded into skid. in & o -> ONE, with the capture loaded into main. !in & o -> EMPTY. Otherwise hold.
  - TWO: o -> ONE, with skid moved to main. Otherwise hold.
  - In TWO no input transfer is possible, because in_ready = 0.
- in_ready = (state != TWO) & ~rst. It depends only on state, never combinationally on out_ready.
- out_valid = (state != EMPTY).
- Latency: 1 cycle from input transfer to out_valid when starting from EMPTY. Throughput: 1 transfer per cycle when out_ready is held high.
- Stall rule: while out_valid & !out_ready, out and out_err stay bit-stable.
- Ordering: strict FIFO; no drop and no duplication.
- Reset (asynchronous, immediate, including mid-transfer):
  - state = EMPTY, out = 0, out_err = 0, out_valid = 0, sel_err_cnt = 0.
  - Skid contents are discarded.
  - in_ready = 0 while rst is high and 1 from the first cycle after deassertion.
- in_valid is ignored while in_ready = 0; data presented then is not captured.
- Unused packed bits: none. All NUM_IN*WIDTH bits are significant.

Test Plan:
- Default params; after reset, in_data = {24'hD, 24'hC, 24'hB, 24'hA}, sel = 2, in_valid = 1, out_ready = 1 for one cycle -> next cycle out = 24'hC, out_valid = 1, out_err = 0; following cycle out_valid = 0.
- Streaming with out_ready = 1 and sel = 0,1,2,3 on consecutive cycles -> out = A, B, C, D on consecutive cycles, 1-cycle latency, and in_ready stays 1 throughout.
- Backpressure: out_ready = 0 while sending sel = 1 then sel = 3 -> state TWO, in_ready = 0, and out holds 24'hB stable. A third beat offered while in_ready = 0 is not captured. Raising out_ready -> out = 24'hB, then 24'hD, then out_valid = 0.
- Out-of-range: NUM_IN = 3, SEL_W = 2, sel = 3 accepted -> out = 0, out_err = 1, sel_err_cnt = 1. After 300 such transfers, sel_err_cnt = 255.
- Async reset in state TWO mid-stall -> out_valid, out, out_err and sel_err_cnt are 0 immediately, without waiting for a clk edge. in_ready = 0 during rst and 1 one cycle after release. The skid beat is never output.
- Random in_valid/out_ready (1000 beats, WIDTH = 8, NUM_IN = 16) against a scoreboard model -> output sequence equals the expected input[sel] sequence, and out is stable whenever stalled.
